spu_event_collector: RTL and testbench

// - Receiving end of the snooping unit event output: accepts event beats (id, info, source) over a valid/ready handshake.
// - Keeps one saturating count per event id and time-stamps every accepted event into a record FIFO.
// - Raises a sticky threshold interrupt per event id.
// - Sits between snooping_unit event output and the SoC register/DMA side that drains records.

---
 rtl/spu_pkg.sv | 30 +++
 rtl/spu_event_collector_if.sv | 31 +++
 rtl/spu_evt_fifo.sv | 60 ++++++
 rtl/spu_event_collector.sv | 158 +++++++++++++++
 tb/tb_spu_event_collector.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spu_pkg.sv
// spu_pkg: shared types for the SPU event collector slice.
// Record struct macro, default record type, drop counter width.
`ifndef SPU_EVT_REC_T
`define SPU_EVT_REC_T(name, tsw, srcw, idw, infow) \
  typedef struct packed { \
    logic [(tsw)-1:0]   ts; \
    logic [(srcw)-1:0]  src; \
    logic [(idw)-1:0]   id; \
    logic [(infow)-1:0] info; \
  } name;
`endif

package spu_pkg;

  localparam int DROP_CNT_W = 16;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_EVENT  = 5;
  localparam int DEF_NUM_SOURCE = 1;
  localparam int DEF_INFO_W     = 1;
  localparam int DEF_TS_W       = 16;
  localparam int DEF_ID_W       = clog2_min1(DEF_NUM_EVENT);
  localparam int DEF_SRC_W      = clog2_min1(DEF_NUM_SOURCE);

  `SPU_EVT_REC_T(evt_rec_t, DEF_TS_W, DEF_SRC_W, DEF_ID_W, DEF_INFO_W)

endpackage

// File: rtl/spu_event_collector_if.sv
// spu_event_collector_if: event beat valid/ready channel.
// master = snooping unit side, slave = collector side.
interface spu_event_collector_if #(
  parameter int ID_W   = 3,
  parameter int INFO_W = 1,
  parameter int SRC_W  = 1
);

  logic              e_valid;
  logic              e_ready;
  logic [ID_W-1:0]   e_id;
  logic [INFO_W-1:0] e_info;
  logic [SRC_W-1:0]  e_src;

  modport master (
    output e_valid,
    output e_id,
    output e_info,
    output e_src,
    input  e_ready
  );

  modport slave (
    input  e_valid,
    input  e_id,
    input  e_info,
    input  e_src,
    output e_ready
  );

endinterface

// File: rtl/spu_evt_fifo.sv
// spu_evt_fifo: sync-reset record FIFO, head shown combinationally.
// push_i/pop_i/data_i in; data_o, full_o, empty_o, usage_o out.
module spu_evt_fifo
  import spu_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type rec_t = evt_rec_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  rec_t                   data_i,
  output rec_t                   data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] usage_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  // DEPTH is a power of two, so the MSB of the level means full
  assign full_o  = cnt[AW];
  assign empty_o = (cnt == '0);
  assign usage_o = cnt;
  assign data_o  = empty_o ? '0 : mem[rd_ptr];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/spu_event_collector.sv
// spu_event_collector: per-id saturating counters, sticky irqs,
// time-stamped record FIFO, counter read port, drop counter.
module spu_event_collector
  import spu_pkg::*;
#(
  parameter int NUM_EVENT       = 5,
  parameter int EVENT_INFO_BITS = 1,
  parameter int NUM_SOURCE      = 1,
  parameter int CNT_WIDTH       = 32,
  parameter int TS_WIDTH        = 16,
  parameter int FIFO_DEPTH      = 8,
  localparam int ID_W  = clog2_min1(NUM_EVENT),
  localparam int SRC_W = clog2_min1(NUM_SOURCE),
  localparam int REC_W = TS_WIDTH + SRC_W + ID_W + EVENT_INFO_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  spu_event_collector_if.slave  e_if,
  input  logic [CNT_WIDTH-1:0]  thr_i,
  input  logic [NUM_EVENT-1:0]  clr_i,
  input  logic [NUM_EVENT-1:0]  irq_clr_i,
  output logic [NUM_EVENT-1:0]  irq_o,
  input  logic                  rd_en_i,
  input  logic [ID_W-1:0]       rd_addr_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rec_valid_o,
  input  logic                  rec_ready_i,
  output logic [REC_W-1:0]      rec_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  `SPU_EVT_REC_T(rec_t, TS_WIDTH, SRC_W, ID_W, EVENT_INFO_BITS)

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = 1;
  localparam logic [TS_WIDTH-1:0]   TS_ONE  = 1;
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = 1;

  logic [TS_WIDTH-1:0]       ts_q;
  logic                      ready;
  logic                      acc;
  logic                      id_ok;
  logic                      src_ok;
  logic                      good;
  logic                      bad;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_usage;
  logic                      unused_usage;
  rec_t                      wr_rec;
  rec_t                      head_rec;
  logic [CNT_WIDTH-1:0]      cnt_all [NUM_EVENT];

  // ready is gated by reset so nothing is taken while state clears
  assign ready      = enable_i & ~fifo_full & ~rst_i;
  assign e_if.e_ready = ready;
  assign acc        = e_if.e_valid & ready;
  assign id_ok      = (32'(e_if.e_id) < NUM_EVENT);
  assign src_ok     = (32'(e_if.e_src) < NUM_SOURCE);
  assign good       = acc & id_ok & src_ok;
  assign bad        = acc & ~(id_ok & src_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_q + TS_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
    end else if (bad && drop_cnt_o != '1) begin
      drop_cnt_o <= drop_cnt_o + DROP_ONE;
    end
  end

  always_comb begin
    wr_rec      = '0;
    wr_rec.ts   = ts_q;
    wr_rec.src  = e_if.e_src;
    wr_rec.id   = e_if.e_id;
    wr_rec.info = e_if.e_info;
  end

  assign pop = ~fifo_empty & rec_ready_i;

  spu_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (good),
    .pop_i   (pop),
    .data_i  (wr_rec),
    .data_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  assign unused_usage = ^fifo_usage;
  assign rec_valid_o  = ~fifo_empty;
  assign rec_o        = head_rec;

  for (genvar k = 0; k < NUM_EVENT; k++) begin : g_evt
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 irq_q;
    logic                 inc;
    logic                 fire;

    assign inc = good & (32'(e_if.e_id) == k);

    // crossing thr by one step means the old count is thr-1;
    // a saturated count never equals thr-1 for any legal thr
    assign fire = inc & ~clr_i[k] & (thr_i != '0)
                & (cnt_q == thr_i - CNT_ONE);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (clr_i[k]) begin
        cnt_q <= '0;
      end else if (inc && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        irq_q <= 1'b0;
      end else if (fire) begin
        irq_q <= 1'b1;
      end else if (irq_clr_i[k]) begin
        irq_q <= 1'b0;
      end
    end

    assign cnt_all[k] = cnt_q;
    assign irq_o[k]   = irq_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) begin
        rd_data_o <= (32'(rd_addr_i) < NUM_EVENT)
                   ? cnt_all[rd_addr_i] : '0;
      end
    end
  end

endmodule

// File: tb/tb_spu_event_collector.sv
// tb_spu_event_collector: random + directed bench with a
// queue/array reference model stepped once per clock.
module tb_spu_event_collector;
  import spu_pkg::*;

  localparam int NE    = 5;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic [31:0] thr;
  logic [4:0]  clr;
  logic [4:0]  irq_clr;
  logic [4:0]  irq;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rec_valid;
  logic        rec_ready;
  logic [20:0] rec_o;
  logic [15:0] drop;

  spu_event_collector_if #(.ID_W(3), .INFO_W(1), .SRC_W(1)) eif ();

  spu_event_collector dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (en),
    .e_if        (eif),
    .thr_i       (thr),
    .clr_i       (clr),
    .irq_clr_i   (irq_clr),
    .irq_o       (irq),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .rec_valid_o (rec_valid),
    .rec_ready_i (rec_ready),
    .rec_o       (rec_o),
    .drop_cnt_o  (drop)
  );

  // narrow-counter instance for the saturation case
  logic        s_en;
  logic [2:0]  s_thr;
  logic [4:0]  s_clr;
  logic [4:0]  s_irq_clr;
  logic [4:0]  s_irq;
  logic        s_rd_en;
  logic [2:0]  s_rd_addr;
  logic [2:0]  s_rd_data;
  logic        s_rd_valid;
  logic        s_rec_valid;
  logic        s_rec_ready;
  logic [20:0] s_rec;
  logic [15:0] s_drop;

  spu_event_collector_if #(.ID_W(3), .INFO_W(1), .SRC_W(1)) sif ();

  spu_event_collector #(.CNT_WIDTH(3)) dut_s (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (s_en),
    .e_if        (sif),
    .thr_i       (s_thr),
    .clr_i       (s_clr),
    .irq_clr_i   (s_irq_clr),
    .irq_o       (s_irq),
    .rd_en_i     (s_rd_en),
    .rd_addr_i   (s_rd_addr),
    .rd_data_o   (s_rd_data),
    .rd_valid_o  (s_rd_valid),
    .rec_valid_o (s_rec_valid),
    .rec_ready_i (s_rec_ready),
    .rec_o       (s_rec),
    .drop_cnt_o  (s_drop)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_cnt [NE];
  logic [4:0]  m_irq;
  logic [15:0] m_drop;
  logic [15:0] m_ts;
  logic [31:0] m_rd_data;
  logic        m_rd_valid;
  evt_rec_t    m_q [$];
  logic        dut_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < NE; k++) m_cnt[k] = '0;
    m_irq      = '0;
    m_drop     = '0;
    m_ts       = '0;
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_q.delete();
  endtask

  // one clock: compare DUT with model, advance model, cross the edge
  task automatic step();
    logic        rdy;
    logic        acc;
    logic        inc;
    logic        fire;
    logic [31:0] old;
    logic [31:0] nc;
    evt_rec_t    r;
    evt_rec_t    head;
    #1;
    rdy  = !rst && en && (m_q.size() < DEPTH);
    acc  = eif.e_valid && rdy;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    chk("e_ready", 64'(eif.e_ready), 64'(rdy));
    chk("rec_valid", 64'(rec_valid), 64'(m_q.size() != 0));
    chk("rec", 64'(rec_o), 64'(head));
    chk("irq", 64'(irq), 64'(m_irq));
    chk("drop", 64'(drop), 64'(m_drop));
    chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    chk("rd_data", 64'(rd_data), 64'(m_rd_data));
    dut_acc = eif.e_valid & eif.e_ready;
    if (rst) begin
      m_reset();
    end else begin
      m_rd_valid = rd_en;
      if (rd_en) m_rd_data = (rd_addr < NE) ? m_cnt[rd_addr] : '0;
      if (rec_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (acc) begin
        if (eif.e_id < NE && eif.e_src < 1) begin
          r.ts   = m_ts;
          r.src  = eif.e_src;
          r.id   = eif.e_id;
          r.info = eif.e_info;
          m_q.push_back(r);
        end else if (m_drop != 16'hFFFF) begin
          m_drop = m_drop + 16'd1;
        end
      end
      for (int k = 0; k < NE; k++) begin
        inc  = acc && eif.e_id == k && eif.e_src < 1;
        old  = m_cnt[k];
        if (clr[k])                        nc = '0;
        else if (inc && old != 32'hFFFF_FFFF) nc = old + 32'd1;
        else                               nc = old;
        fire = inc && !clr[k] && (old < thr) && (nc >= thr);
        if (fire)            m_irq[k] = 1'b1;
        else if (irq_clr[k]) m_irq[k] = 1'b0;
        m_cnt[k] = nc;
      end
      m_ts = m_ts + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] id, input logic src,
                      input logic info);
    eif.e_valid = 1'b1;
    eif.e_id    = id;
    eif.e_src   = src;
    eif.e_info  = info;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a,
                        input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en   = 1'b0;
    chk(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic drain();
    eif.e_valid = 1'b0;
    rec_ready   = 1'b1;
    repeat (DEPTH + 2) step();
    rec_ready   = 1'b0;
  endtask

  evt_rec_t hr;
  logic [15:0] ts_v [3];
  int n_acc;

  initial begin
    rst = 1'b1; en = 1'b0; thr = '0; clr = '0; irq_clr = '0;
    rd_en = 1'b0; rd_addr = '0; rec_ready = 1'b0;
    eif.e_valid = 1'b0; eif.e_id = '0; eif.e_src = '0; eif.e_info = '0;
    s_en = 1'b0; s_thr = '0; s_clr = '0; s_irq_clr = '0;
    s_rd_en = 1'b0; s_rd_addr = '0; s_rec_ready = 1'b0;
    sif.e_valid = 1'b0; sif.e_id = '0; sif.e_src = '0; sif.e_info = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    en  = 1'b1;

    // three back-to-back id=2 beats, thr=3
    thr = 32'd3;
    beat(3'd2, 1'b0, 1'b1);
    step();
    step();
    chk("t1_irq_early", 64'(irq), 64'(5'b00000));
    step();
    eif.e_valid = 1'b0;
    chk("t1_irq", 64'(irq), 64'(5'b00100));
    rd_chk("t1_cnt2", 3'd2, 32'd3);
    for (int i = 0; i < 3; i++) begin
      hr = evt_rec_t'(rec_o);
      ts_v[i] = hr.ts;
      chk("t1_rec_id", 64'(hr.id), 64'(2));
      rec_ready = 1'b1;
      step();
    end
    rec_ready = 1'b0;
    chk("t1_ts_step1", 64'(ts_v[1] - ts_v[0]), 64'(1));
    chk("t1_ts_step2", 64'(ts_v[2] - ts_v[1]), 64'(1));
    chk("t1_empty", 64'(rec_valid), 64'(0));

    // fill the FIFO: 8 accepted, the 9th waits for a pop
    n_acc = 0;
    beat(3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (dut_acc) n_acc++;
    end
    chk("t2_accepts", 64'(n_acc), 64'(8));
    rec_ready = 1'b1;
    step();
    chk("t2_pop_cycle", 64'(dut_acc), 64'(0));
    rec_ready = 1'b0;
    step();
    chk("t2_ninth", 64'(dut_acc), 64'(1));
    drain();

    // out-of-range id and source are dropped
    beat(3'd5, 1'b0, 1'b0);
    step();
    beat(3'd0, 1'b1, 1'b0);
    step();
    eif.e_valid = 1'b0;
    step();
    chk("t3_drop", 64'(drop), 64'(2));
    chk("t3_no_rec", 64'(rec_valid), 64'(0));
    rd_chk("t3_cnt0", 3'd0, 32'd0);
    rd_chk("t3_cnt1", 3'd1, 32'd9);

    // clear and increment in the same cycle
    beat(3'd1, 1'b0, 1'b1);
    clr = 5'b00010;
    step();
    clr = '0;
    eif.e_valid = 1'b0;
    step();
    chk("t4_rec", 64'(rec_valid), 64'(1));
    rd_chk("t4_cnt1", 3'd1, 32'd0);
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    chk("t4_one_rec", 64'(rec_valid), 64'(0));
    rd_chk("t4_bad_addr", 3'd6, 32'd0);

    // saturation on the 3-bit instance, thr = all ones
    s_en = 1'b1; s_thr = 3'd7; s_rec_ready = 1'b1;
    sif.e_valid = 1'b1; sif.e_id = 3'd0;
    repeat (6) step();
    chk("sat_irq_early", 64'(s_irq[0]), 64'(0));
    step();
    chk("sat_irq", 64'(s_irq[0]), 64'(1));
    s_irq_clr = 5'b00001;
    step();
    s_irq_clr = '0;
    repeat (2) step();
    sif.e_valid = 1'b0;
    chk("sat_no_refire", 64'(s_irq[0]), 64'(0));
    s_rd_en = 1'b1; s_rd_addr = 3'd0;
    step();
    s_rd_en = 1'b0;
    chk("sat_cnt", 64'(s_rd_data), 64'(7));
    chk("sat_rd_valid", 64'(s_rd_valid), 64'(1));
    step();
    chk("sat_drained", 64'(s_rec_valid), 64'(0));
    chk("sat_rec_zero", 64'(s_rec), 64'(0));
    chk("sat_drop", 64'(s_drop), 64'(0));

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) thr = 32'($urandom_range(0, 12));
      if (!eif.e_valid || dut_acc) begin
        eif.e_valid = ($urandom_range(0, 3) != 0);
        eif.e_id    = 3'($urandom_range(0, 7));
        eif.e_src   = ($urandom_range(0, 7) == 0);
        eif.e_info  = ($urandom_range(0, 1) == 1);
      end
      en        = ($urandom_range(0, 7) != 0);
      rec_ready = ($urandom_range(0, 1) == 1);
      rd_en     = ($urandom_range(0, 2) == 0);
      rd_addr   = 3'($urandom_range(0, 7));
      for (int k = 0; k < NE; k++) begin
        clr[k]     = ($urandom_range(0, 15) == 0);
        irq_clr[k] = ($urandom_range(0, 7) == 0);
      end
      step();
    end
    clr = '0; irq_clr = '0; rd_en = 1'b0; en = 1'b1;
    drain();

    // reset with 4 records queued and irq[3] set
    clr = 5'b01000;
    step();
    clr = '0;
    thr = 32'd1;
    beat(3'd3, 1'b0, 1'b0);
    repeat (4) step();
    eif.e_valid = 1'b0;
    beat(3'd7, 1'b0, 1'b0);
    step();
    eif.e_valid = 1'b0;
    chk("t7_pre_irq", 64'(irq[3]), 64'(1));
    chk("t7_pre_rec", 64'(rec_valid), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t7_rec_valid", 64'(rec_valid), 64'(0));
    chk("t7_irq", 64'(irq), 64'(0));
    chk("t7_drop", 64'(drop), 64'(0));
    for (int a = 0; a < NE; a++) rd_chk("t7_cnt", 3'(a), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
